// File: rtl/uart_apb_pkg.sv
// Shared constants and types for the UART receiver APB poll controller.
// Register addresses, controller states and receive-error codes.
package uart_apb_pkg;

  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_ERROR  = 3'd1;
  localparam logic [2:0] ADDR_BP_LO  = 3'd2;
  localparam logic [2:0] ADDR_BP_HI  = 3'd3;
  localparam logic [2:0] ADDR_SIZE   = 3'd4;
  localparam logic [2:0] ADDR_DATA   = 3'd6;

  typedef enum logic [2:0] {
    StIdle,
    StCfg,
    StStat,
    StErr,
    StData,
    StPush,
    StGap
  } ctrl_state_t;

  typedef enum logic [1:0] {
    RxErrNone    = 2'b00,
    RxErrFraming = 2'b01,
    RxErrOverrun = 2'b10
  } rx_err_t;

  // Peripheral error register value -> downstream error code.
  function automatic rx_err_t map_err_code(input logic [7:0] code);
    rx_err_t res;
    case (code)
      8'd1:    res = RxErrFraming;
      8'd2:    res = RxErrOverrun;
      default: res = RxErrNone;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/apb_xfer_phase.sv
// Zero-wait APB master phase engine: one start gives SETUP then ACCESS.
// A start during ACCESS issues a back-to-back SETUP on the next cycle.
module apb_xfer_phase (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [2:0] addr_i,
  input  logic       write_i,
  input  logic [7:0] wdata_i,
  output logic       psel_o,
  output logic       penable_o,
  output logic       pwrite_o,
  output logic [2:0] paddr_o,
  output logic [7:0] pwdata_o,
  input  logic [7:0] prdata_i,
  input  logic       pslverr_i,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic       err_o
);

  logic       psel_q, psel_d;
  logic       penable_q, penable_d;
  logic       pwrite_q, pwrite_d;
  logic [2:0] paddr_q, paddr_d;
  logic [7:0] pwdata_q, pwdata_d;

  always_comb begin
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    if (start_i) begin
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = write_i;
      paddr_d   = addr_i;
      pwdata_d  = wdata_i;
    end else if (psel_q && !penable_q) begin
      penable_d = 1'b1;
    end else begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= 3'd0;
      pwdata_q  <= 8'd0;
    end else begin
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  // Completion is reported during ACCESS so the caller can chain the next SETUP.
  assign done_o    = psel_q & penable_q;
  assign err_o     = done_o & pslverr_i;
  assign rdata_o   = done_o ? prdata_i : 8'd0;
  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;

endmodule

// File: rtl/uart_rx_poll_ctrl.sv
// APB sequencer owning the UART receiver: configures it, polls status and
// streams {err, byte} downstream; slave errors abort to idle and stick.
module uart_rx_poll_ctrl
  import uart_apb_pkg::*;
#(
  parameter int unsigned PollGap = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        cfg_start_i,
  input  logic [13:0] cfg_bit_period_i,
  input  logic [3:0]  cfg_data_size_i,
  output logic        cfg_done_o,
  output logic        busy_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [2:0]  paddr_o,
  output logic [7:0]  pwdata_o,
  input  logic [7:0]  prdata_i,
  input  logic        pslverr_i,
  output logic [7:0]  rx_data_o,
  output logic [1:0]  rx_err_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        slverr_sticky_o,
  input  logic        slverr_clr_i
);

  localparam int unsigned GapW = (PollGap > 1) ? $clog2(PollGap) : 1;

  ctrl_state_t     state_q, state_d;
  logic [5:0]      bp_hi_q, bp_hi_d;
  logic [3:0]      size_q, size_d;
  logic [1:0]      cfg_idx_q, cfg_idx_d;
  logic            configured_q, configured_d;
  logic            cfg_done_q, cfg_done_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]      rx_data_q, rx_data_d;
  rx_err_t         rx_err_q, rx_err_d;
  logic            slverr_q, slverr_d;

  logic       x_start, x_write, x_done, x_err;
  logic [2:0] x_addr;
  logic [7:0] x_wdata, x_rdata;

  apb_xfer_phase u_xfer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (x_start),
    .addr_i    (x_addr),
    .write_i   (x_write),
    .wdata_i   (x_wdata),
    .psel_o    (psel_o),
    .penable_o (penable_o),
    .pwrite_o  (pwrite_o),
    .paddr_o   (paddr_o),
    .pwdata_o  (pwdata_o),
    .prdata_i  (prdata_i),
    .pslverr_i (pslverr_i),
    .done_o    (x_done),
    .rdata_o   (x_rdata),
    .err_o     (x_err)
  );

  always_comb begin
    state_d      = state_q;
    bp_hi_d      = bp_hi_q;
    size_d       = size_q;
    cfg_idx_d    = cfg_idx_q;
    configured_d = configured_q;
    cfg_done_d   = 1'b0;
    gap_cnt_d    = '0;
    rx_data_d    = rx_data_q;
    rx_err_d     = rx_err_q;
    x_start      = 1'b0;
    x_write      = 1'b0;
    x_addr       = ADDR_STATUS;
    x_wdata      = 8'd0;

    // Set wins over clear.
    if (x_err) begin
      slverr_d = 1'b1;
    end else if (slverr_clr_i) begin
      slverr_d = 1'b0;
    end else begin
      slverr_d = slverr_q;
    end

    unique case (state_q)
      StIdle: begin
        if (cfg_start_i) begin
          bp_hi_d   = cfg_bit_period_i[13:8];
          size_d    = cfg_data_size_i;
          cfg_idx_d = 2'd0;
          x_start   = 1'b1;
          x_write   = 1'b1;
          x_addr    = ADDR_BP_LO;
          x_wdata   = cfg_bit_period_i[7:0];
          state_d   = StCfg;
        end else if (enable_i && configured_q) begin
          x_start = 1'b1;
          x_addr  = ADDR_STATUS;
          state_d = StStat;
        end
      end
      StCfg: begin
        if (x_err) begin
          configured_d = 1'b0;
          state_d      = StIdle;
        end else if (x_done) begin
          if (cfg_idx_q == 2'd2) begin
            configured_d = 1'b1;
            cfg_done_d   = 1'b1;
            state_d      = StIdle;
          end else begin
            cfg_idx_d = cfg_idx_q + 2'd1;
            x_start   = 1'b1;
            x_write   = 1'b1;
            if (cfg_idx_q == 2'd0) begin
              x_addr  = ADDR_BP_HI;
              x_wdata = {2'b00, bp_hi_q};
            end else begin
              x_addr  = ADDR_SIZE;
              x_wdata = {4'b0000, size_q};
            end
          end
        end
      end
      StStat: begin
        if (x_err) begin
          state_d = StIdle;
        end else if (x_done) begin
          if (x_rdata[0]) begin
            x_start = 1'b1;
            x_addr  = ADDR_ERROR;
            state_d = StErr;
          end else begin
            state_d = StGap;
          end
        end
      end
      StErr: begin
        if (x_err) begin
          state_d = StIdle;
        end else if (x_done) begin
          rx_err_d = map_err_code(x_rdata);
          x_start  = 1'b1;
          x_addr   = ADDR_DATA;
          state_d  = StData;
        end
      end
      StData: begin
        if (x_err) begin
          state_d = StIdle;
        end else if (x_done) begin
          rx_data_d = x_rdata;
          state_d   = StPush;
        end
      end
      StPush: begin
        if (rx_ready_i) begin
          state_d = StGap;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapW'(PollGap - 1)) begin
          if (enable_i) begin
            x_start = 1'b1;
            x_addr  = ADDR_STATUS;
            state_d = StStat;
          end else begin
            state_d = StIdle;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      bp_hi_q      <= 6'd0;
      size_q       <= 4'd0;
      cfg_idx_q    <= 2'd0;
      configured_q <= 1'b0;
      cfg_done_q   <= 1'b0;
      gap_cnt_q    <= '0;
      rx_data_q    <= 8'd0;
      rx_err_q     <= RxErrNone;
      slverr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      bp_hi_q      <= bp_hi_d;
      size_q       <= size_d;
      cfg_idx_q    <= cfg_idx_d;
      configured_q <= configured_d;
      cfg_done_q   <= cfg_done_d;
      gap_cnt_q    <= gap_cnt_d;
      rx_data_q    <= rx_data_d;
      rx_err_q     <= rx_err_d;
      slverr_q     <= slverr_d;
    end
  end

  assign cfg_done_o      = cfg_done_q;
  assign busy_o          = (state_q != StIdle);
  assign rx_valid_o      = (state_q == StPush);
  assign rx_data_o       = rx_data_q;
  assign rx_err_o        = rx_err_q;
  assign slverr_sticky_o = slverr_q;

endmodule
